// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake stream blocks: width derivation,
// parameter legality checks and the per-edge transfer classification.
package handshake_pkg;

    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int depth, input int af_thresh);
        return is_pow2(depth) && (depth >= 2) && (af_thresh >= 1) && (af_thresh <= depth);
    endfunction

endpackage

// File: rtl/handshake_out_reg.sv
// Registered head stage: holds the word currently offered downstream and
// refills from storage, or straight from upstream when storage is empty.
module handshake_out_reg #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load,
    input  logic                  mem_avail,
    input  logic [WORD_WIDTH-1:0] mem_data,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    output logic                  down_valid,
    output logic [WORD_WIDTH-1:0] down_data
);

    // Storage always wins over the bypass so older words leave first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
        end else if (flush) begin
            down_valid <= 1'b0;
        end else if (load) begin
            if (mem_avail) begin
                down_valid <= 1'b1;
                down_data  <= mem_data;
            end else if (push) begin
                down_valid <= 1'b1;
                down_data  <= push_data;
            end else begin
                down_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/handshake_elastic_buf.sv
// Valid/ready elastic buffer: head register plus circular storage, with all
// handshake outputs registered so upstream and downstream never see each other.
module handshake_elastic_buf
    import handshake_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          up_valid,
    input  logic [WORD_WIDTH-1:0]         up_data,
    output logic                          up_ready,
    output logic                          down_valid,
    output logic [WORD_WIDTH-1:0]         down_data,
    input  logic                          down_ready,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          almost_full
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    if (!params_ok(DEPTH, AF_THRESH)) begin : g_param_check
        $error("handshake_elastic_buf: DEPTH must be a power of two >= 2 and AF_THRESH in 1..DEPTH");
    end

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;
    logic                  advance;
    logic                  mem_empty;
    logic                  mem_wr;
    logic                  mem_rd;
    xfer_e                 xfer;

    // Storage holds everything behind the head, so it is empty while count <= 1.
    assign push      = up_valid && up_ready;
    assign pop       = down_valid && down_ready;
    assign advance   = !down_valid || down_ready;
    assign mem_empty = (count <= ONE_CNT);
    assign mem_rd    = !flush && advance && !mem_empty;
    assign mem_wr    = !flush && push && !(advance && mem_empty);
    assign xfer      = xfer_e'({push, pop});

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case (xfer)
                XFER_PUSH: count_next = count + ONE_CNT;
                XFER_POP:  count_next = count - ONE_CNT;
                default:   count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            up_ready    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
                if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            up_ready    <= (count_next != FULL_CNT);
            almost_full <= (count_next >= AF_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr] <= up_data;
    end

    handshake_out_reg #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (advance),
        .mem_avail  (!mem_empty),
        .mem_data   (mem[rd_ptr]),
        .push       (push),
        .push_data  (up_data),
        .down_valid (down_valid),
        .down_data  (down_data)
    );

endmodule

// File: tb/tb_handshake_elastic_buf.sv
// Self-checking bench: a queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_handshake_elastic_buf;

    localparam int WORD_WIDTH = 8;
    localparam int DEPTH      = 4;
    localparam int AF_THRESH  = 3;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  up_valid = 1'b0;
    logic [WORD_WIDTH-1:0] up_data = '0;
    logic                  down_ready = 1'b0;
    logic                  up_ready;
    logic                  down_valid;
    logic [WORD_WIDTH-1:0] down_data;
    logic [CNT_W-1:0]      count;
    logic                  almost_full;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [WORD_WIDTH-1:0] mq [$];
    bit                    m_up_ready   = 1'b0;
    bit                    m_down_valid = 1'b0;
    bit                    m_push;
    bit                    m_pop;
    logic [CNT_W-1:0]      max_seen = '0;
    logic [7:0]            fill_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    handshake_elastic_buf #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF_THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_ready    (up_ready),
        .down_valid  (down_valid),
        .down_data   (down_data),
        .down_ready  (down_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic f);
        up_valid   = v;
        up_data    = d;
        down_ready = r;
        flush      = f;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain FIFO queue whose handshake flags follow its size.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_up_ready   = 1'b0;
            m_down_valid = 1'b0;
        end else begin
            m_push = up_valid && m_up_ready;
            m_pop  = m_down_valid && down_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(up_data);
            end
            m_up_ready   = (mq.size() != DEPTH);
            m_down_valid = (mq.size() != 0);
        end
    end

    always @(negedge clk) begin
        checkOutput("m_up_ready", {31'b0, up_ready}, {31'b0, m_up_ready});
        checkOutput("m_down_valid", {31'b0, down_valid}, {31'b0, m_down_valid});
        checkOutput("m_count", 32'(count), 32'(mq.size()));
        checkOutput("m_almost_full", {31'b0, almost_full}, {31'b0, mq.size() >= AF_THRESH});
        if (m_down_valid) checkOutput("m_down_data", 32'(down_data), 32'(mq[0]));
    end

    initial begin
        // Reset held for two edges
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_up_ready", {31'b0, up_ready}, 32'd0);
        checkOutput("rst_down_valid", {31'b0, down_valid}, 32'd0);
        checkOutput("rst_down_data", 32'(down_data), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_almost_full", {31'b0, almost_full}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("pre_edge_up_ready", {31'b0, up_ready}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("post_rst_up_ready", {31'b0, up_ready}, 32'd1);
        checkOutput("post_rst_count", 32'(count), 32'd0);

        // Fill with back-pressure
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, fill_words[i], 1'b0, 1'b0);
            checkOutput("fill_down_data", 32'(down_data), 32'h11);
            checkOutput("fill_down_valid", {31'b0, down_valid}, 32'd1);
            if (i == 2) checkOutput("fill_af_at_3", {31'b0, almost_full}, 32'd1);
        end
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_up_ready", {31'b0, up_ready}, 32'd0);

        // Drain from full
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_down_data", 32'(down_data), 32'(fill_words[i]));
            checkOutput("drain_down_valid", {31'b0, down_valid}, 32'd1);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (i == 0) checkOutput("drain_up_ready", {31'b0, up_ready}, 32'd1);
        end
        checkOutput("drained_down_valid", {31'b0, down_valid}, 32'd0);
        checkOutput("drained_count", 32'(count), 32'd0);

        // Continuous pushes with toggling back-pressure
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 8'($urandom), (i % 2) == 0, 1'b0);
            if (count > max_seen) max_seen = count;
        end
        checkOutput("count_le_depth", {31'b0, max_seen <= 3'd4}, 32'd1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        checkOutput("sim_full_count", 32'(count), 32'd4);
        applyStimulus(1'b1, 8'hA0, 1'b1, 1'b0);
        checkOutput("sim_pop_only_count", 32'(count), 32'd3);
        checkOutput("sim_up_ready", {31'b0, up_ready}, 32'd1);
        applyStimulus(1'b1, 8'hA1, 1'b1, 1'b0);
        checkOutput("sim_both_count", 32'(count), 32'd3);

        // Flush with a word offered in the same cycle
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pre_flush_empty", 32'(count), 32'd0);
        applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
        checkOutput("pre_flush_count", 32'(count), 32'd2);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_down_valid", {31'b0, down_valid}, 32'd0);
        checkOutput("flush_up_ready", {31'b0, up_ready}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_no_ghost", {31'b0, down_valid}, 32'd0);

        // Refill to three, then reset between edges
        applyStimulus(1'b1, 8'h71, 1'b0, 1'b0);
        checkOutput("refill_head", 32'(down_data), 32'h71);
        applyStimulus(1'b1, 8'h72, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h73, 1'b0, 1'b0);
        checkOutput("refill_count", 32'(count), 32'd3);
        up_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_up_ready", {31'b0, up_ready}, 32'd0);
        checkOutput("async_down_valid", {31'b0, down_valid}, 32'd0);
        checkOutput("async_down_data", 32'(down_data), 32'd0);
        checkOutput("async_count", 32'(count), 32'd0);
        checkOutput("async_almost_full", {31'b0, almost_full}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
        checkOutput("recover_head", 32'(down_data), 32'h81);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("recover_empty", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
